avmm_capture_slave: RTL and testbench

AVMM_CAPTURE_SLAVE -- requirements
Module: avmm_capture_slave

---
 rtl/avmm_capture_pkg.sv | 8 +
 rtl/avmm_wait_gen.sv | 28 ++
 rtl/avmm_capture_slave.sv | 69 ++++++
 tb/tb_avmm_capture_slave.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/avmm_capture_pkg.sv
// Shared constants for the Avalon-MM capture slave: register offsets and default ID.
package avmm_capture_pkg;
   localparam logic [1:0]  OFF_SCRATCH  = 2'd0;
   localparam logic [1:0]  OFF_WRCOUNT  = 2'd1;
   localparam logic [1:0]  OFF_LASTDATA = 2'd2;
   localparam logic [1:0]  OFF_ID       = 2'd3;
   localparam logic [31:0] ID_DEFAULT   = 32'hC0DE_0001;
endpackage

// File: rtl/avmm_wait_gen.sv
// Wait-state generator: holds waitrequest for WAIT_STATES cycles per transfer,
// then emits a one-cycle completion strobe.
module avmm_wait_gen #(
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_req,
   output logic o_waitrequest,
   output logic o_complete
);
   localparam logic [3:0] LP_WS = 4'(WAIT_STATES);

   logic [3:0] r_cnt;

   assign o_waitrequest = i_req && (r_cnt != LP_WS);
   assign o_complete    = i_req && !o_waitrequest;

   // Restart from zero after every completion so a held request becomes a new transfer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_cnt <= '0;
      else if (!i_req || o_complete)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + 4'd1;
   end
endmodule

// File: rtl/avmm_capture_slave.sv
// Avalon-MM slave with scratch, write counter, last-write capture and ID registers.
module avmm_capture_slave
   import avmm_capture_pkg::*;
#(
   parameter int unsigned WAIT_STATES = 2,
   parameter logic [31:0] ID_VALUE    = ID_DEFAULT
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   input  logic [3:0]  byteenable,
   output logic [31:0] readdata,
   output logic        waitrequest
);
   logic [31:0] r_scratch;
   logic [31:0] r_wrcount;
   logic [31:0] r_lastdata;
   logic        w_complete;
   logic        w_wr_commit;
   logic        w_rd_commit;
   logic [31:0] w_rdata;

   avmm_wait_gen #(.WAIT_STATES(WAIT_STATES)) u_wait_gen (
      .clk           (clk),
      .reset_n       (reset_n),
      .i_req         (read | write),
      .o_waitrequest (waitrequest),
      .o_complete    (w_complete)
   );

   // A simultaneous read and write is handled as a write only.
   assign w_wr_commit = w_complete && write;
   assign w_rd_commit = w_complete && read && !write;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_scratch  <= '0;
         r_wrcount  <= '0;
         r_lastdata <= '0;
      end else if (w_wr_commit) begin
         r_lastdata <= writedata;
         if (address == OFF_SCRATCH) begin
            for (int b = 0; b < 4; b++)
               if (byteenable[b])
                  r_scratch[8*b +: 8] <= writedata[8*b +: 8];
         end
         if (address == OFF_WRCOUNT)
            r_wrcount <= '0;
         else if (r_wrcount != 32'hFFFF_FFFF)
            r_wrcount <= r_wrcount + 32'd1;
      end
   end

   always_comb begin
      w_rdata = '0;
      case (address)
         OFF_SCRATCH:  w_rdata = r_scratch;
         OFF_WRCOUNT:  w_rdata = r_wrcount;
         OFF_LASTDATA: w_rdata = r_lastdata;
         OFF_ID:       w_rdata = ID_VALUE;
         default:      w_rdata = '0;
      endcase
   end

   assign readdata = w_rd_commit ? w_rdata : 32'd0;
endmodule

// File: tb/tb_avmm_capture_slave.sv
// Scoreboard bench: two instances (WAIT_STATES=2 and WAIT_STATES=0) driven by directed vectors.
module tb_avmm_capture_slave;
   logic        clk = 1'b0;
   logic        reset_n, rst0_n;
   logic [1:0]  address, m0_address;
   logic        read, write, m0_read, m0_write;
   logic [31:0] writedata, m0_writedata;
   logic [3:0]  byteenable, m0_byteenable;
   logic [31:0] readdata, m0_readdata;
   logic        waitrequest, m0_wait;

   int errors = 0;
   int checks = 0;
   logic [31:0] q_exp[$];
   logic [31:0] q0_exp[$];

   localparam logic [31:0] ID0 = 32'h0BAD_F00D;

   always #5 clk = ~clk;

   avmm_capture_slave #(.WAIT_STATES(2)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
      .writedata(writedata), .byteenable(byteenable), .readdata(readdata),
      .waitrequest(waitrequest)
   );

   avmm_capture_slave #(.WAIT_STATES(0), .ID_VALUE(ID0)) dut0 (
      .clk(clk), .reset_n(rst0_n), .address(m0_address), .read(m0_read), .write(m0_write),
      .writedata(m0_writedata), .byteenable(m0_byteenable), .readdata(m0_readdata),
      .waitrequest(m0_wait)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitors: pop the expected value whenever a read completes, else readdata must be 0.
   always @(negedge clk) begin
      if (read && !write && !waitrequest) begin
         if (q_exp.size() == 0) chk("unexpected_read_ws2", 32'd1, 32'd0);
         else chk("readdata_ws2", readdata, q_exp.pop_front());
      end else begin
         chk("readdata_idle_ws2", readdata, 32'd0);
      end
   end

   always @(negedge clk) begin
      if (m0_read && !m0_write && !m0_wait) begin
         if (q0_exp.size() == 0) chk("unexpected_read_ws0", 32'd1, 32'd0);
         else chk("readdata_ws0", m0_readdata, q0_exp.pop_front());
      end else begin
         chk("readdata_idle_ws0", m0_readdata, 32'd0);
      end
   end

   task automatic wait_done(input string name, input int exp_waits);
      int  waits = 0;
      bit  done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (waitrequest) waits++;
         else done = 1;
      end
      chk({name, "_timeout"}, 32'(done), 32'd1);
      chk({name, "_waits"}, 32'(waits), 32'(exp_waits));
   endtask

   task automatic do_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be,
                           input string name);
      address = a; writedata = d; byteenable = be; write = 1'b1;
      wait_done(name, 2);
      @(posedge clk); #1;
      write = 1'b0;
   endtask

   task automatic do_read(input logic [1:0] a, input logic [31:0] exp, input string name);
      q_exp.push_back(exp);
      address = a; read = 1'b1;
      wait_done(name, 2);
      @(posedge clk); #1;
      read = 1'b0;
   endtask

   task automatic m0_rd(input logic [1:0] a, input logic [31:0] exp);
      q0_exp.push_back(exp);
      m0_address = a; m0_read = 1'b1;
      @(negedge clk);
      chk("ws0_read_wait", 32'(m0_wait), 32'd0);
      @(posedge clk); #1;
      m0_read = 1'b0;
   endtask

   initial begin
      logic [31:0] b2b [4];
      b2b[0] = 32'h0000_0011; b2b[1] = 32'h0000_0022;
      b2b[2] = 32'h0000_0033; b2b[3] = 32'h0000_0044;
      reset_n = 1'b0; rst0_n = 1'b0;
      address = '0; read = 0; write = 0; writedata = '0; byteenable = '0;
      m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_wait_idle", 32'(waitrequest), 32'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      do_read(2'd0, 32'd0, "rst_scratch");
      do_read(2'd1, 32'd0, "rst_wrcount");
      do_read(2'd2, 32'd0, "rst_lastdata");
      do_read(2'd3, 32'hC0DE_0001, "id");

      do_write(2'd0, 32'h1234_5678, 4'hF, "wr_full");
      do_read(2'd0, 32'h1234_5678, "scratch1");
      do_read(2'd1, 32'd1, "wrcount1");
      do_read(2'd2, 32'h1234_5678, "lastdata1");

      do_write(2'd0, 32'hAAAA_AAAA, 4'b0101, "wr_be");
      do_read(2'd0, 32'h12AA_56AA, "scratch_be");
      do_read(2'd1, 32'd2, "wrcount2");

      // Aborted write: dropped after one wait cycle, then one idle cycle.
      address = 2'd0; writedata = 32'hFFFF_FFFF; byteenable = 4'hF; write = 1'b1;
      @(posedge clk); #1;
      write = 1'b0;
      @(posedge clk); #1;
      chk("idle_wait", 32'(waitrequest), 32'd0);
      do_read(2'd0, 32'h12AA_56AA, "abort_scratch");
      do_read(2'd1, 32'd2, "abort_wrcount");

      do_write(2'd2, 32'h1111_1111, 4'hF, "wr_off2");
      do_write(2'd3, 32'h2222_2222, 4'hF, "wr_off3");
      do_write(2'd0, 32'h3333_3333, 4'h0, "wr_be0");
      do_read(2'd1, 32'd5, "wrcount5");
      do_read(2'd0, 32'h12AA_56AA, "scratch_be0");
      do_read(2'd2, 32'h3333_3333, "lastdata3");
      do_write(2'd1, 32'h4444_4444, 4'hF, "wr_clear");
      do_read(2'd1, 32'd0, "wrcount_clr");
      do_read(2'd2, 32'h4444_4444, "lastdata_clr");

      read = 1'b1;
      do_write(2'd0, 32'h5555_5555, 4'hF, "wr_and_rd");
      read = 1'b0;
      do_read(2'd0, 32'h5555_5555, "rw_scratch");
      do_read(2'd1, 32'd1, "rw_wrcount");

      // Reset during the second wait cycle of a held write.
      address = 2'd0; writedata = 32'h6666_6666; byteenable = 4'hF; write = 1'b1;
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      chk("reset_mid_wait", 32'(waitrequest), 32'd1);
      @(posedge clk); #1;
      reset_n = 1'b1;
      wait_done("post_reset_wr", 2);
      @(posedge clk); #1;
      write = 1'b0;
      do_read(2'd1, 32'd1, "post_reset_wrcount");
      do_read(2'd0, 32'h6666_6666, "post_reset_scratch");

      // Zero wait states: a read completes combinationally even while in reset.
      m0_address = 2'd3; m0_read = 1'b1;
      q0_exp.push_back(ID0);
      @(negedge clk);
      chk("ws0_reset_wait", 32'(m0_wait), 32'd0);
      @(posedge clk); #1;
      m0_read = 1'b0; rst0_n = 1'b1;
      @(posedge clk); #1;
      m0_byteenable = 4'hF; m0_write = 1'b1;
      for (int i = 0; i < 4; i++) begin
         m0_address = 2'd0; m0_writedata = b2b[i];
         @(negedge clk);
         chk("ws0_b2b_wait", 32'(m0_wait), 32'd0);
         @(posedge clk); #1;
      end
      m0_write = 1'b0;
      m0_rd(2'd1, 32'd4);
      m0_rd(2'd0, 32'h0000_0044);
      m0_rd(2'd3, ID0);

      @(posedge clk); #1;
      chk("queue_drain_ws2", 32'(q_exp.size()), 32'd0);
      chk("queue_drain_ws0", 32'(q0_exp.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
